ft64_icache_x1: RTL

FT64_ICACHE_X1 -- requirements
Module: FT64_icache_x1

---
 rtl/ft64_icache_x1.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/ft64_icache_x1.sv
// Direct-mapped instruction cache: 32-byte lines, 48-bit fetch window that may
// straddle two lines, with line refills done as four 64-bit bus beats.
module ft64_icache_x1 #(
   parameter int AMSB  = 31,
   parameter int LINES = 64
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AMSB:0] pc,
   output logic [47:0]   insn0,
   output logic          phit,
   input  logic          invall,
   input  logic          invline,
   input  logic [AMSB:0] invadr,
   output logic          cyc_o,
   output logic          stb_o,
   input  logic          ack_i,
   output logic [AMSB:0] adr_o,
   input  logic [63:0]   dat_i
);

   localparam int IW = $clog2(LINES);
   localparam int LW = AMSB - 4;
   localparam int TW = LW - IW;

   typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

   state_t           state_reg, state_next;
   logic [LW-1:0]    target_reg, target_next;
   logic [1:0]       beat_reg, beat_next;
   logic             cyc_reg, cyc_next;
   logic             stb_reg, stb_next;
   logic             stale_reg, stale_next;
   logic [AMSB:0]    adr_reg, adr_next;
   logic [LINES-1:0] valid_reg, valid_next;

   logic [TW-1:0]    tag_mem [LINES];

   logic [AMSB:0]    pc_a, pc_b;
   logic [LW-1:0]    line_a, line_b, inv_line;
   logic [IW-1:0]    idx_a, idx_b, idx_t, idx_inv;
   logic             straddle, hit_a, hit_b, inv_hit;
   logic             fill_we, done_we, inv_target, done_ok;
   logic [3:0][63:0] word_a, word_b;
   logic [511:0]     window;
   logic             unused_bits;

   // Fetch is halfword aligned, so bit 0 of pc never takes part.
   assign pc_a     = {pc[AMSB:1], 1'b0};
   assign pc_b     = pc_a + (AMSB+1)'(5);
   assign line_a   = pc_a[AMSB:5];
   assign line_b   = pc_b[AMSB:5];
   assign inv_line = invadr[AMSB:5];
   assign idx_a    = line_a[IW-1:0];
   assign idx_b    = line_b[IW-1:0];
   assign idx_t    = target_reg[IW-1:0];
   assign idx_inv  = inv_line[IW-1:0];
   assign straddle = pc_a[4:0] > 5'd26;

   assign hit_a   = valid_reg[idx_a] && (tag_mem[idx_a] == line_a[LW-1:IW]);
   assign hit_b   = valid_reg[idx_b] && (tag_mem[idx_b] == line_b[LW-1:IW]);
   assign inv_hit = invline && (tag_mem[idx_inv] == inv_line[LW-1:IW]);

   assign phit = (state_reg == IDLE) && hit_a && (!straddle || hit_b);

   // One 64-bit wide storage lane per bus beat; each lane is read for both lines.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         logic [63:0] lane_mem [LINES];
         always_ff @(posedge clk) begin
            if (fill_we && beat_reg == 2'(gi))
               lane_mem[idx_t] <= dat_i;
         end
         assign word_a[gi] = lane_mem[idx_a];
         assign word_b[gi] = lane_mem[idx_b];
      end
   endgenerate

   assign window = {word_b, word_a};
   assign insn0  = 48'(window >> {pc_a[4:0], 3'b000});

   always_ff @(posedge clk) begin
      if (done_we)
         tag_mem[idx_t] <= target_reg[LW-1:IW];
   end

   assign inv_target = invall || (invline && inv_line == target_reg);
   assign done_ok    = done_we && !stale_reg && !inv_target;

   // Invalidation is applied after the fill validate so it always wins.
   always_comb begin
      valid_next = valid_reg;
      if (done_ok)
         valid_next[idx_t] = 1'b1;
      if (inv_hit && !(done_we && idx_inv == idx_t))
         valid_next[idx_inv] = 1'b0;
      if (invall)
         valid_next = '0;
   end

   always_comb begin
      state_next  = state_reg;
      target_next = target_reg;
      beat_next   = beat_reg;
      cyc_next    = cyc_reg;
      stb_next    = stb_reg;
      adr_next    = adr_reg;
      stale_next  = stale_reg;
      fill_we     = 1'b0;
      done_we     = 1'b0;
      case (state_reg)
         IDLE: begin
            stale_next = 1'b0;
            if (!hit_a || (straddle && !hit_b)) begin
               target_next = hit_a ? line_b : line_a;
               beat_next   = 2'd0;
               cyc_next    = 1'b1;
               stb_next    = 1'b1;
               adr_next    = {target_next, 5'b00000};
               state_next  = FILL;
            end
         end
         FILL: begin
            if (inv_target)
               stale_next = 1'b1;
            if (ack_i) begin
               fill_we   = 1'b1;
               beat_next = beat_reg + 2'd1;
               if (beat_reg == 2'd3) begin
                  cyc_next   = 1'b0;
                  stb_next   = 1'b0;
                  state_next = DONE;
               end else begin
                  adr_next = {target_reg, beat_next, 3'b000};
               end
            end
         end
         DONE: begin
            done_we    = 1'b1;
            stale_next = 1'b0;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         target_reg <= '0;
         beat_reg   <= 2'd0;
         cyc_reg    <= 1'b0;
         stb_reg    <= 1'b0;
         adr_reg    <= '0;
         stale_reg  <= 1'b0;
         valid_reg  <= '0;
      end else begin
         state_reg  <= state_next;
         target_reg <= target_next;
         beat_reg   <= beat_next;
         cyc_reg    <= cyc_next;
         stb_reg    <= stb_next;
         adr_reg    <= adr_next;
         stale_reg  <= stale_next;
         valid_reg  <= valid_next;
      end
   end

   assign cyc_o = cyc_reg;
   assign stb_o = stb_reg;
   assign adr_o = adr_reg;

   assign unused_bits = ^{pc[0], pc_b[4:0], invadr[4:0]};

endmodule
